// File: rtl/floor_request_scheduler.sv
// Three-floor elevator scheduler: latches floor calls, sequences travel/door/emergency states.
// All outputs are registered; floor moves every TRAVEL_CYCLES edges, door holds DOOR_CYCLES edges.
module floor_request_scheduler #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic st_floor_button,
    input  logic nd_floor_button,
    input  logic rd_floor_button,
    input  logic sos_button,
    input  logic weight_sensor,
    output logic st_floor_led,
    output logic nd_floor_led,
    output logic rd_floor_led,
    output logic st_floor_indicator,
    output logic nd_floor_indicator,
    output logic rd_floor_indicator,
    output logic door_status_led,
    output logic moving_up,
    output logic moving_down,
    output logic sos_led,
    output logic emergency_led,
    output logic weight_led
);

    typedef enum logic [2:0] {IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN, EMERGENCY} state_t;

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    state_t        state_q, state_d;
    logic [2:0]    floor_q, floor_d;   // one-hot, bit 0 = floor 1
    logic [2:0]    pend_q, pend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          dir_q, dir_d;       // last travel direction, 1 = up
    logic          door_q, door_d;
    logic          up_q, up_d;
    logic          down_q, down_d;
    logic          emerg_q, emerg_d;
    logic          weight_q;

    logic [2:0] btn, set, clr, nxt;
    logic       going_up;

    // Prefer continuing in direction 'up'; reverse only if nothing lies ahead.
    function automatic state_t next_move(input logic [2:0] pend, input logic [2:0] f, input logic up);
        logic [2:0] above, below, ahead, behind;
        above  = {f[1] | f[0], f[0], 1'b0};
        below  = {1'b0, f[2], f[2] | f[1]};
        ahead  = up ? (pend & above) : (pend & below);
        behind = up ? (pend & below) : (pend & above);
        if (ahead != 3'b000)       return up ? MOVING_UP : MOVING_DOWN;
        else if (behind != 3'b000) return up ? MOVING_DOWN : MOVING_UP;
        else                       return IDLE;
    endfunction

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        dir_d    = dir_q;
        btn      = {rd_floor_button, nd_floor_button, st_floor_button};
        set      = btn;
        clr      = 3'b000;
        going_up = (state_q == MOVING_UP);
        nxt      = going_up ? {floor_q[1:0], 1'b0} : {1'b0, floor_q[2:1]};

        case (state_q)
            IDLE: begin
                set = btn & ~floor_q;
                if ((btn & floor_q) != 3'b000 || (pend_q & floor_q) != 3'b000) begin
                    state_d = DOOR_OPEN;
                    dcnt_d  = DOOR_LOAD;
                    clr     = floor_q;
                end else if (pend_q != 3'b000 && !weight_sensor) begin
                    state_d = next_move(pend_q, floor_q, 1'b0);
                    tcnt_d  = TRAVEL_LOAD;
                end
            end
            MOVING_UP, MOVING_DOWN: begin
                if (tcnt_q != '0) begin
                    tcnt_d = tcnt_q - TW'(1);
                end else if (nxt == 3'b000) begin
                    state_d = IDLE;
                end else begin
                    floor_d = nxt;
                    if ((pend_q & nxt) != 3'b000) begin
                        // Serving this floor: a press on the arrival edge must not re-arm it.
                        clr     = nxt;
                        set     = btn & ~nxt;
                        state_d = DOOR_OPEN;
                        dcnt_d  = DOOR_LOAD;
                    end else begin
                        state_d = next_move(pend_q, nxt, going_up);
                        tcnt_d  = TRAVEL_LOAD;
                    end
                end
            end
            DOOR_OPEN: begin
                set = btn & ~floor_q;
                if (weight_sensor) begin
                    dcnt_d = DOOR_LOAD;
                end else if (dcnt_q == '0) begin
                    state_d = next_move(pend_q, floor_q, dir_q);
                    tcnt_d  = TRAVEL_LOAD;
                end else if ((btn & floor_q) != 3'b000) begin
                    dcnt_d = DOOR_LOAD;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            EMERGENCY: begin
                set = 3'b000;
                if (!sos_button) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pend_d = (pend_q & ~clr) | set;

        if (sos_button) begin
            state_d = EMERGENCY;
            pend_d  = 3'b000;
            floor_d = floor_q;
        end

        if (state_d == MOVING_UP)        dir_d = 1'b1;
        else if (state_d == MOVING_DOWN) dir_d = 1'b0;

        door_d  = (state_d == DOOR_OPEN);
        up_d    = (state_d == MOVING_UP);
        down_d  = (state_d == MOVING_DOWN);
        emerg_d = (state_d == EMERGENCY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            floor_q  <= 3'b001;
            pend_q   <= 3'b000;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            dir_q    <= 1'b1;
            door_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            emerg_q  <= 1'b0;
            weight_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            dir_q    <= dir_d;
            door_q   <= door_d;
            up_q     <= up_d;
            down_q   <= down_d;
            emerg_q  <= emerg_d;
            weight_q <= weight_sensor;
        end
    end

    assign {rd_floor_led, nd_floor_led, st_floor_led}                   = pend_q;
    assign {rd_floor_indicator, nd_floor_indicator, st_floor_indicator} = floor_q;
    assign door_status_led = door_q;
    assign moving_up       = up_q;
    assign moving_down     = down_q;
    assign sos_led         = emerg_q;
    assign emergency_led   = emerg_q;
    assign weight_led      = weight_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: cycle table for a full 1->3 trip,
// then hand sequences for door hold/restart, overload, SOS, reversal and async reset.
module tb_floor_request_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic st_b, nd_b, rd_b, sos, wt;
    logic st_led, nd_led, rd_led, st_ind, nd_ind, rd_ind;
    logic door, up, dn, sos_led, emg_led, wled;

    floor_request_scheduler #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
        .clk(clk), .reset(reset),
        .st_floor_button(st_b), .nd_floor_button(nd_b), .rd_floor_button(rd_b),
        .sos_button(sos), .weight_sensor(wt),
        .st_floor_led(st_led), .nd_floor_led(nd_led), .rd_floor_led(rd_led),
        .st_floor_indicator(st_ind), .nd_floor_indicator(nd_ind), .rd_floor_indicator(rd_ind),
        .door_status_led(door), .moving_up(up), .moving_down(dn),
        .sos_led(sos_led), .emergency_led(emg_led), .weight_led(wled)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F1 = 3'b001, F2 = 3'b010, F3 = 3'b100, NONE = 3'b000;

    int checks = 0;
    int failures = 0;

    // {floor 3..1, pending 3..1, door, up, down, emergency, sos, weight}
    logic [11:0] obs;
    assign obs = {rd_ind, nd_ind, st_ind, rd_led, nd_led, st_led, door, up, dn, emg_led, sos_led, wled};

    function automatic logic [11:0] ex(input logic [2:0] flr, input logic [2:0] pend,
                                       input logic d, input logic u, input logic w_dn,
                                       input logic e, input logic wl);
        return {flr, pend, d, u, w_dn, e, e, wl};
    endfunction

    typedef struct {
        logic [2:0]  btn;
        logic        wt;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] b, input logic w, input logic [11:0] e);
        vec_t v;
        v.btn = b;
        v.wt  = w;
        v.exp = e;
        return v;
    endfunction

    vec_t vt[$];

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (flr3..1 pend3..1 door up dn emg sos wled)", name, obs, exp);
        end
    endtask

    task automatic tick(input logic [2:0] b, input logic s, input logic w);
        {rd_b, nd_b, st_b} = b;
        sos = s;
        wt  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(NONE, 1'b0, 1'b0);
    endtask

    task automatic wait_door_open(input string name, input int budget);
        int n;
        n = 0;
        while (door !== 1'b1 && n < budget) begin
            tick(NONE, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (door !== 1'b1) begin
            failures++;
            $display("FAIL %s: door_status_led=%b after %0d cycles, required 1", name, door, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {st_b, nd_b, rd_b, sos, wt} = 5'b0;

        // 1 -> 3 trip, one edge per row; rd pressed again on the arrival edge must not re-arm.
        vt.push_back(mk(F3, 1'b0, ex(F1, F3, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) vt.push_back(mk(NONE, 1'b0, ex(F1, F3, 0, 1, 0, 0, 0)));
        for (int i = 0; i < 4; i++) vt.push_back(mk(NONE, 1'b0, ex(F2, F3, 0, 1, 0, 0, 0)));
        vt.push_back(mk(F3, 1'b0, ex(F3, NONE, 1, 0, 0, 0, 0)));
        for (int i = 0; i < 5; i++) vt.push_back(mk(NONE, 1'b0, ex(F3, NONE, 1, 0, 0, 0, 0)));
        vt.push_back(mk(NONE, 1'b0, ex(F3, NONE, 0, 0, 0, 0, 0)));
        vt.push_back(mk(NONE, 1'b1, ex(F3, NONE, 0, 0, 0, 0, 1)));
        vt.push_back(mk(NONE, 1'b0, ex(F3, NONE, 0, 0, 0, 0, 0)));

        #12;
        check("reset_state", ex(F1, NONE, 0, 0, 0, 0, 0));
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].btn, 1'b0, vt[i].wt);
            check($sformatf("trip_vec%0d", i), vt[i].exp);
        end

        // Current-floor press in IDLE opens door; press on 5th door cycle restarts timer.
        tick(F3, 1'b0, 1'b0);
        check("r24_open", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(4);
        tick(F3, 1'b0, 1'b0);
        check("r24_press", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(1);
        check("r24_e6", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(4);
        check("r24_e10", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(1);
        check("r24_close", ex(F3, NONE, 0, 0, 0, 0, 0));

        // Overload holds the door open for 10 cycles; closes 6 edges after last high edge.
        tick(F3, 1'b0, 1'b0);
        check("r22_open", ex(F3, NONE, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            tick(NONE, 1'b0, 1'b1);
            if (k == 1)  check("r22_wled_on", ex(F3, NONE, 1, 0, 0, 0, 1));
            if (k == 10) check("r22_hold", ex(F3, NONE, 1, 0, 0, 0, 1));
        end
        tick(NONE, 1'b0, 1'b0);
        check("r22_wled_off", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(4);
        check("r22_e15", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(1);
        check("r22_close", ex(F3, NONE, 0, 0, 0, 0, 0));

        // Overload blocks departure from IDLE.
        tick(F1, 1'b0, 1'b1);
        check("wt_latch", ex(F3, F1, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) tick(NONE, 1'b0, 1'b1);
        check("wt_block", ex(F3, F1, 0, 0, 0, 0, 1));
        tick(NONE, 1'b0, 1'b0);
        check("wt_depart", ex(F3, F1, 0, 0, 1, 0, 0));
        wait_door_open("wt_arrive_wait", 20);
        check("wt_arrive", ex(F1, NONE, 1, 0, 0, 0, 0));
        idle(6);
        check("wt_idle", ex(F1, NONE, 0, 0, 0, 0, 0));

        // SOS two cycles into a 1 -> 3 trip.
        tick(F3, 1'b0, 1'b0);
        tick(NONE, 1'b0, 1'b0);
        check("r23_go", ex(F1, F3, 0, 1, 0, 0, 0));
        tick(NONE, 1'b0, 1'b0);
        tick(NONE, 1'b1, 1'b0);
        check("r23_sos", ex(F1, NONE, 0, 0, 0, 1, 0));
        tick(F2, 1'b1, 1'b0);
        check("r23_ignore", ex(F1, NONE, 0, 0, 0, 1, 0));
        tick(NONE, 1'b0, 1'b0);
        check("r23_release", ex(F1, NONE, 0, 0, 0, 0, 0));
        idle(4);
        check("r23_still", ex(F1, NONE, 0, 0, 0, 0, 0));

        // Floor 2 with calls both sides: down first, then reverse up to floor 3.
        tick(F2, 1'b0, 1'b0);
        idle(5);
        check("r21_setup", ex(F2, NONE, 1, 0, 0, 0, 0));
        idle(6);
        check("r21_idle", ex(F2, NONE, 0, 0, 0, 0, 0));
        tick(F1 | F3, 1'b0, 1'b0);
        check("r21_latch", ex(F2, F1 | F3, 0, 0, 0, 0, 0));
        tick(NONE, 1'b0, 1'b0);
        check("r21_down_first", ex(F2, F1 | F3, 0, 0, 1, 0, 0));
        idle(4);
        check("r21_door1", ex(F1, F3, 1, 0, 0, 0, 0));
        idle(6);
        check("r21_up", ex(F1, F3, 0, 1, 0, 0, 0));
        idle(4);
        check("r21_pass2", ex(F2, F3, 0, 1, 0, 0, 0));
        idle(4);
        check("r21_door3", ex(F3, NONE, 1, 0, 0, 0, 0));
        idle(6);
        check("r21_done", ex(F3, NONE, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-travel, then resume on first edge after release.
        tick(F1, 1'b0, 1'b0);
        tick(NONE, 1'b0, 1'b0);
        tick(NONE, 1'b0, 1'b0);
        check("rst_pre", ex(F3, F1, 0, 0, 1, 0, 0));
        #3 reset = 1'b1;
        #1;
        check("rst_async", ex(F1, NONE, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;
        tick(F3, 1'b0, 1'b0);
        check("rst_resume", ex(F1, F3, 0, 0, 0, 0, 0));
        tick(NONE, 1'b0, 1'b0);
        check("rst_move", ex(F1, F3, 0, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
